// File: rtl/ltl_report_collector.sv
// Collects report vectors from one LTL automaton cluster into a timestamped FIFO.
// Also keeps sticky report flags, saturating event/drop counters and an overflow flag.
module ltl_report_collector #(
  parameter int NUM_REPORTS = 4,
  parameter int POS_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NUM_REPORTS-1:0] report_vec,
  input  logic                   clear_sticky,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_REPORTS-1:0] out_reports,
  output logic [POS_WIDTH-1:0]   out_pos,
  output logic [NUM_REPORTS-1:0] sticky_reports,
  output logic [CNT_WIDTH-1:0]   event_count,
  output logic [CNT_WIDTH-1:0]   drop_count,
  output logic                   overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = NUM_REPORTS + POS_WIDTH;

  logic [POS_WIDTH-1:0]   pos;
  logic [AW:0]            wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [EW-1:0]          head_nxt;
  logic                   ev, full, pop, push, drop;
  logic [CNT_WIDTH-1:0]   ev_base, drop_base, ev_nxt, drop_nxt;
  logic [NUM_REPORTS-1:0] sticky_base;
  logic                   ovf_base;

  always_comb begin
    ev   = run && (report_vec != '0);
    full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop  = out_valid && out_ready;
    push = ev && (!full || pop);
    drop = ev && !push;
    wr_nxt = push ? wr_ptr + (AW+1)'(1) : wr_ptr;
    rd_nxt = pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;

    // Outputs are registered, so the next head is chosen here; a lone new
    // entry has not reached mem yet and is taken straight from the inputs.
    head_nxt = '0;
    if (wr_nxt != rd_nxt) begin
      if (push && (rd_nxt[AW-1:0] == wr_ptr[AW-1:0]))
        head_nxt = {report_vec, pos};
      else
        head_nxt = mem[rd_nxt[AW-1:0]];
    end
  end

  // A clear coinciding with an event zeroes history first, then counts the event.
  always_comb begin
    ev_base     = clear_sticky ? '0 : event_count;
    drop_base   = clear_sticky ? '0 : drop_count;
    sticky_base = clear_sticky ? '0 : sticky_reports;
    ovf_base    = clear_sticky ? 1'b0 : overflow;
    ev_nxt      = ev_base;
    drop_nxt    = drop_base;
    if (push && (ev_base != '1))
      ev_nxt = ev_base + CNT_WIDTH'(1);
    if (drop && (drop_base != '1))
      drop_nxt = drop_base + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pos            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      out_valid      <= 1'b0;
      out_reports    <= '0;
      out_pos        <= '0;
      sticky_reports <= '0;
      event_count    <= '0;
      drop_count     <= '0;
      overflow       <= 1'b0;
    end else begin
      if (run)
        pos <= pos + POS_WIDTH'(1);
      wr_ptr         <= wr_nxt;
      rd_ptr         <= rd_nxt;
      out_valid      <= (wr_nxt != rd_nxt);
      out_reports    <= head_nxt[EW-1:POS_WIDTH];
      out_pos        <= head_nxt[POS_WIDTH-1:0];
      sticky_reports <= sticky_base | (run ? report_vec : '0);
      event_count    <= ev_nxt;
      drop_count     <= drop_nxt;
      overflow       <= ovf_base | drop;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {report_vec, pos};
  end

endmodule

// File: tb/tb_ltl_report_collector.sv
// Self-checking bench for ltl_report_collector: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_ltl_report_collector;

  localparam int NR    = 4;
  localparam int PW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, run, clear_sticky, out_ready;
  logic [NR-1:0] report_vec;
  logic          out_valid, overflow;
  logic [NR-1:0] out_reports, sticky_reports;
  logic [PW-1:0] out_pos;
  logic [CW-1:0] event_count, drop_count;

  ltl_report_collector #(
    .NUM_REPORTS(NR),
    .POS_WIDTH  (PW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .report_vec    (report_vec),
    .clear_sticky  (clear_sticky),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_reports   (out_reports),
    .out_pos       (out_pos),
    .sticky_reports(sticky_reports),
    .event_count   (event_count),
    .drop_count    (drop_count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: entries hold {reports, pos}.
  logic [NR+PW-1:0] q[$];
  int unsigned m_pos, m_sticky, m_ev, m_drop, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop, ev, full;
    logic [NR+PW-1:0] ent;
    if (!reset) begin
      q.delete();
      m_pos = 0; m_sticky = 0; m_ev = 0; m_drop = 0; m_ovf = 0;
      return;
    end
    pop  = (q.size() > 0) && out_ready;
    ev   = run && (report_vec != 0);
    full = (q.size() == DEPTH);
    if (clear_sticky) begin
      m_sticky = 0; m_ev = 0; m_drop = 0; m_ovf = 0;
    end
    if (pop) void'(q.pop_front());
    if (ev) begin
      m_sticky = m_sticky | report_vec;
      if (!full || pop) begin
        ent = {report_vec, m_pos[PW-1:0]};
        q.push_back(ent);
        if (m_ev < CMAX) m_ev++;
      end else begin
        if (m_drop < CMAX) m_drop++;
        m_ovf = 1;
      end
    end
    if (run) m_pos = (m_pos + 1) % (1 << PW);
  endtask

  task automatic compare();
    logic [NR+PW-1:0] h;
    h = (q.size() > 0) ? q[0] : '0;
    chk("out_valid",   out_valid,      (q.size() > 0));
    chk("out_reports", out_reports,    h[NR+PW-1:PW]);
    chk("out_pos",     out_pos,        h[PW-1:0]);
    chk("sticky",      sticky_reports, m_sticky);
    chk("event_count", event_count,    m_ev);
    chk("drop_count",  drop_count,     m_drop);
    chk("overflow",    overflow,       m_ovf);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic drive(input logic r, input logic rn, input logic [NR-1:0] rv,
                       input logic c, input logic rdy);
    reset = r; run = rn; report_vec = rv; clear_sticky = c; out_ready = rdy;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(); step();
  endtask

  initial begin
    logic [PW-1:0] exp_pos [4];
    exp_pos[0] = 1; exp_pos[1] = 2; exp_pos[2] = 3; exp_pos[3] = 6;

    // Reset and idle, then confirm pos via the next event.
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_evcnt", event_count, 0);
    for (int i = 0; i < 10; i++) begin drive(1'b1, 1'b1, '0, 1'b0, 1'b0); step(); end
    chk("idle_valid", out_valid, 0);
    drive(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0); step();
    chk("idle_pos10", out_pos, 10);

    // Single event at pos 5.
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b1, '0, 1'b0, 1'b1); step(); end
    drive(1'b1, 1'b1, 4'b0100, 1'b0, 1'b1); step();
    chk("single_valid", out_valid, 1);
    chk("single_rep",   out_reports, 4'b0100);
    chk("single_pos",   out_pos, 5);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1); step();
    chk("single_acc",    out_valid, 0);
    chk("single_sticky", sticky_reports, 4'b0100);
    chk("single_evcnt",  event_count, 1);

    // Overflow, then full FIFO with simultaneous push and pop, then drain.
    do_reset();
    for (int i = 0; i < 6; i++) begin drive(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0); step(); end
    chk("ovf_drop",  drop_count, 2);
    chk("ovf_flag",  overflow, 1);
    chk("ovf_evcnt", event_count, 4);
    chk("ovf_head",  out_pos, 0);
    drive(1'b1, 1'b1, 4'b1000, 1'b0, 1'b1); step();
    chk("pp_drop",  drop_count, 2);
    chk("pp_evcnt", event_count, 5);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pos", out_pos, exp_pos[i]);
      drive(1'b1, 1'b0, '0, 1'b0, 1'b1); step();
    end
    chk("drain_empty", out_valid, 0);

    // run gating and position wrap.
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 4'b1111, 1'b0, 1'b0); step(); end
    chk("gate_valid",  out_valid, 0);
    chk("gate_sticky", sticky_reports, 0);
    for (int i = 0; i < 17; i++) begin drive(1'b1, 1'b1, '0, 1'b0, 1'b0); step(); end
    drive(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0); step();
    chk("wrap_pos", out_pos, 1);

    // Clear coinciding with an accepted event, then with a dropped event.
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0); step(); end
    drive(1'b1, 1'b1, 4'b0010, 1'b1, 1'b0); step();
    chk("clr_sticky", sticky_reports, 4'b0010);
    chk("clr_evcnt",  event_count, 1);
    chk("clr_ovf",    overflow, 0);
    drive(1'b1, 1'b1, 4'b0100, 1'b1, 1'b0); step();
    chk("clrd_evcnt", event_count, 0);
    chk("clrd_drop",  drop_count, 1);
    chk("clrd_ovf",   overflow, 1);

    // Reset while an entry is being offered.
    drive(1'b0, 1'b1, 4'b0011, 1'b0, 1'b1); step();
    chk("mid_rst_valid", out_valid, 0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1); step();
    chk("mid_rst_empty", out_valid, 0);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) begin drive(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0); step(); end
    chk("sat_drop", drop_count, CMAX);
    for (int i = 0; i < 300; i++) begin drive(1'b1, 1'b1, 4'b0001, 1'b1 * (i == 0), 1'b1); step(); end
    chk("sat_ev", event_count, CMAX);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      drive(($urandom_range(0, 499) != 0), $urandom_range(0, 3) != 0,
            ($urandom_range(0, 2) == 0) ? '0 : NR'($urandom),
            ($urandom_range(0, 149) == 0), $urandom_range(0, 1) == 1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
